vlane_store_packer: RTL
=======================

VLANE_STORE_PACKER -- requirements
Module: vlane_store_packer

Interface
REQ-001 The block SHALL have one clock, clk; its reset, rstn, SHALL be asynchronous and active-low.
REQ-002 Parameter VLANE_NUM, default 4: number of vector lanes per store beat, from 1 to 16.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32: output stream width in bits, one of 32, 64 or 128.
REQ-004 Parameter C_VL_WIDTH, default 32: width of the element-count field.
REQ-005 Port clk, input, 1 bit: the system clock.
REQ-006 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 Port cfg_vld_i, input, 1 bit: a store-transfer request.
REQ-008 Port cfg_rdy_o, output, 1 bit: ready to accept a request; it is high only in IDLE.
REQ-009 Port cfg_sew_i, input, 3 bits: element width; 000 selects 8 bits, 001 selects 16 bits, 010 selects 32 bits, and any other code is treated as 32 bits.
REQ-010 Port cfg_vl_i, input, C_VL_WIDTH bits: number of elements to store.
REQ-011 Port vlane_store_data_i, input, VLANE_NUM x 32 bits: one element per lane, carried in the low SEW bits.
REQ-012 Port vlane_store_dvalid_i, input, 1 bit: the lane beat is valid.
REQ-013 Port vlane_store_rdy_o, output, 1 bit: the packer can accept a lane beat.
REQ-014 Port wr_tdata_o, output, C_M_AXI_DATA_WIDTH bits: packed data.
REQ-015 Port wr_tkeep_o, output, C_M_AXI_DATA_WIDTH/8 bits: byte-valid mask.
REQ-016 Port wr_tvalid_o, output, 1 bit, and port wr_tready_i, input, 1 bit: the output handshake.
REQ-017 Port wr_tlast_o, output, 1 bit: marks the final word of the transfer.
REQ-018 Port done_o, output, 1 bit: a one-cycle pulse when the transfer completes.

Function
REQ-019 A request SHALL be captured when cfg_vld_i and cfg_rdy_o are both high; SEW and vl SHALL be latched, and inputs SHALL be ignored until the next IDLE.
REQ-020 The state machine SHALL have three states: IDLE, then ACCEPT on capture when vl > 0, then DRAIN after the last element is absorbed, then IDLE after the tlast handshake.
REQ-021 When vl = 0, IDLE SHALL stay in IDLE, pulse done_o on the cycle after capture, and emit no output.
REQ-022 A lane beat SHALL transfer when vlane_store_dvalid_i and vlane_store_rdy_o are both high; it contributes min(VLANE_NUM, remaining) elements, lane 0 first, and the surplus lanes of the final beat are discarded.
REQ-023 Element k SHALL be placed little-endian at byte offset (k*SEWB) mod (C_M_AXI_DATA_WIDTH/8), where SEWB is 1, 2 or 4.
REQ-024 A word SHALL be emitted once all its bytes are filled, or once the last element has been absorbed; wr_tkeep_o SHALL be all ones except in a partial final word, where only the filled low bytes are set.
REQ-025 The first output word SHALL be presented 1 to 2 cycles after the lane beat that completes it.
REQ-026 vlane_store_rdy_o SHALL be high only in ACCEPT, and only when the internal buffer has room for VLANE_NUM*SEWB bytes; there SHALL be no combinational path from wr_tready_i to vlane_store_rdy_o.
REQ-027 While wr_tvalid_o is high and wr_tready_i is low, wr_tdata_o, wr_tkeep_o and wr_tlast_o SHALL hold stable; no data SHALL be dropped or duplicated.
REQ-028 wr_tlast_o SHALL be high only on the word that contains element vl-1.
REQ-029 done_o SHALL pulse in the cycle after the tlast handshake.
REQ-030 The element counter SHALL be C_VL_WIDTH bits wide, so the maximum vl of 2^C_VL_WIDTH-1 SHALL complete without wrap-around.
REQ-031 With sustained input and wr_tready_i held high, throughput SHALL be one output word per cycle.

Reset
REQ-032 While rstn is low, wr_tvalid_o, wr_tlast_o, wr_tdata_o, wr_tkeep_o, done_o and vlane_store_rdy_o SHALL be 0, cfg_rdy_o SHALL be 0, and the state SHALL be IDLE.
REQ-033 cfg_rdy_o SHALL go to 1 on the first clk edge after rstn deasserts.
REQ-034 A reset during a transfer SHALL discard all buffered data and counters; no partial word SHALL be emitted afterwards.

Structure
REQ-035 The SEW encoding enum, the sew_bytes() helper function and the state typedef SHALL live in the shared package mem_subsys_pkg.
REQ-036 The output register stage SHALL be a 2-entry skid buffer implemented as the sub-module axis_skid_buf, parameterised by data width.

Verification
REQ-037 With VLANE_NUM=4, DW=32, SEW32 and vl=8, lanes driving iter+i, and tready=1: the bench SHALL see 8 words with values 0 to 7, keep=4'hF, tlast on word 8, and done_o one cycle later.
REQ-038 With SEW8, vl=6 and DW=32: the bench SHALL see word0=32'h03020100 with keep 4'hF, then word1 with low half 16'h0504, keep 4'b0011 and tlast.
REQ-039 With SEW16, vl=1024, DW=32, random tready at 50% and random dvalid: the bench SHALL see 512 in-order words and no stable-data violation while stalled.
REQ-040 With vl=5, SEW32 and VLANE=4: the bench SHALL see the second beat consume only lane 0, 5 words in total, and tlast on word 5.
REQ-041 With vl=0: done_o SHALL pulse one cycle after the request handshake, wr_tvalid_o SHALL never rise, and cfg_rdy_o SHALL be 1 again.
REQ-042 Asserting rstn low after word 3 of a vl=16 transfer SHALL drive outputs to 0 immediately; a following vl=4 transfer SHALL then produce exactly 4 correct words.

Source files
------------

// File: rtl/mem_subsys_pkg.sv
// Shared types and helpers for the memory subsystem: element-width encoding,
// store-packer state encoding and the SEW-to-bytes mapping.
package mem_subsys_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'b000,
    SEW16 = 3'b001,
    SEW32 = 3'b010
  } sew_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int unsigned LANE_W = 32;

  // Reserved SEW codes fall back to 32-bit elements.
  function automatic logic [2:0] sew_bytes(input logic [2:0] sew);
    case (sew)
      SEW8:    return 3'd1;
      SEW16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream register slice: registered output plus one skid entry,
// so in_ready depends only on local state and never on out_ready.
module axis_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;

  // in_ready low means the skid entry is occupied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else if (out_ready || !out_valid) begin
      if (!in_ready) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= in_valid;
        out_data  <= in_valid ? in_data : '0;
      end
    end else if (in_valid && in_ready) begin
      skid_data <= in_data;
      in_ready  <= 1'b0;
    end
  end

endmodule

// File: rtl/vlane_store_packer.sv
// Packs per-lane store elements (8/16/32-bit) into a little-endian byte stream
// and emits it as AXI-stream words with keep/last, ending with a done pulse.
module vlane_store_packer
  import mem_subsys_pkg::*;
#(
  parameter int unsigned VLANE_NUM          = 4,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_VL_WIDTH         = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_vld_i,
  output logic                            cfg_rdy_o,
  input  logic [2:0]                      cfg_sew_i,
  input  logic [C_VL_WIDTH-1:0]           cfg_vl_i,
  input  logic [VLANE_NUM*LANE_W-1:0]     vlane_store_data_i,
  input  logic                            vlane_store_dvalid_i,
  output logic                            vlane_store_rdy_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   wr_tdata_o,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] wr_tkeep_o,
  output logic                            wr_tvalid_o,
  input  logic                            wr_tready_i,
  output logic                            wr_tlast_o,
  output logic                            done_o
);

  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned DWB   = DW / 8;
  localparam int unsigned BEATB = VLANE_NUM * 4;
  localparam int unsigned CAPB  = DWB + BEATB;
  localparam int unsigned CAPW  = CAPB * 8;
  localparam int unsigned FW    = $clog2(CAPB + 1);
  localparam int unsigned LW    = $clog2(VLANE_NUM + 1);
  localparam int unsigned CW    = C_VL_WIDTH;
  localparam int unsigned PW    = DW + DWB + 1;

  state_e             state, state_next;
  logic [2:0]         sewb_q, sewb_next;
  logic [CW-1:0]      remaining, remaining_next;
  logic [FW-1:0]      fill, fill_next;
  logic [CAPW-1:0]    data_buf, data_buf_next;
  logic               cfg_rdy_next, lane_rdy_next, done_next;

  logic               capture, beat_fire, beat_last;
  logic               full_word, pop, pop_last, skid_ready;
  logic [LW-1:0]      n_elem;
  logic [FW-1:0]      beat_bytes, pop_bytes, base;
  logic [BEATB*8-1:0] beat;
  logic [DWB-1:0]     pop_keep;
  logic [FW:0]        room_need;
  logic [PW-1:0]      skid_out;

  // Element count of the current beat; the final beat may use fewer lanes.
  always_comb begin
    capture   = cfg_vld_i && cfg_rdy_o;
    beat_fire = vlane_store_dvalid_i && vlane_store_rdy_o;
    beat_last = {6'd0, remaining} <= (CW + 6)'(VLANE_NUM);
    n_elem    = beat_last ? LW'(remaining) : LW'(VLANE_NUM);
  end

  // Compact the used lanes into a contiguous little-endian byte vector.
  always_comb begin
    beat = '0;
    for (int i = 0; i < VLANE_NUM; i++) begin
      if (LW'(i) < n_elem) begin
        case (sewb_q)
          3'd1:    beat[i*8 +: 8]   = vlane_store_data_i[i*LANE_W +: 8];
          3'd2:    beat[i*16 +: 16] = vlane_store_data_i[i*LANE_W +: 16];
          default: beat[i*32 +: 32] = vlane_store_data_i[i*LANE_W +: 32];
        endcase
      end
    end
    beat_bytes = FW'(n_elem) * FW'(sewb_q);
  end

  // Pop a full word, or the residual partial word once all elements are in.
  always_comb begin
    full_word = fill >= FW'(DWB);
    pop       = skid_ready && (full_word || (state == DRAIN && fill != '0));
    pop_bytes = full_word ? FW'(DWB) : fill;
    pop_last  = (state == DRAIN) && (fill <= FW'(DWB));
    pop_keep  = '0;
    for (int j = 0; j < DWB; j++) begin
      pop_keep[j] = FW'(j) < fill;
    end
    base          = pop ? fill - pop_bytes : fill;
    fill_next     = base + (beat_fire ? beat_bytes : '0);
    data_buf_next = (pop ? data_buf >> DW : data_buf)
                  | (beat_fire ? (CAPW'(beat) << {base, 3'b000}) : '0);
  end

  // Next-state and registered handshake outputs.
  always_comb begin
    state_next     = state;
    sewb_next      = sewb_q;
    remaining_next = remaining;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          sewb_next      = sew_bytes(cfg_sew_i);
          remaining_next = cfg_vl_i;
          if (cfg_vl_i == '0) done_next  = 1'b1;
          else                state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        if (beat_fire) begin
          remaining_next = remaining - CW'(n_elem);
          if (beat_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_tvalid_o && wr_tready_i && wr_tlast_o) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    cfg_rdy_next  = state_next == IDLE;
    room_need     = (FW + 1)'(fill_next) + (FW + 1)'(VLANE_NUM) * (FW + 1)'(sewb_next);
    lane_rdy_next = (state_next == ACCEPT) && (room_need <= (FW + 1)'(CAPB));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      sewb_q            <= 3'd4;
      remaining         <= '0;
      fill              <= '0;
      data_buf          <= '0;
      cfg_rdy_o         <= 1'b0;
      vlane_store_rdy_o <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state             <= state_next;
      sewb_q            <= sewb_next;
      remaining         <= remaining_next;
      fill              <= fill_next;
      data_buf          <= data_buf_next;
      cfg_rdy_o         <= cfg_rdy_next;
      vlane_store_rdy_o <= lane_rdy_next;
      done_o            <= done_next;
    end
  end

  axis_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   ({pop_last, pop_keep, data_buf[DW-1:0]}),
    .in_valid  (pop),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (wr_tvalid_o),
    .out_ready (wr_tready_i)
  );

  assign {wr_tlast_o, wr_tkeep_o, wr_tdata_o} = skid_out;

endmodule
